// File: rtl/t10_lcd_pkg.sv
// Shared definitions for the LCD bus decoder: controller states, HD44780-style
// command opcodes, the blank character and the DDRAM row-2 base address.
package t10_lcd_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FUNC = 2'd0,
    ST_CONFIG    = 2'd1,
    ST_RUN       = 2'd2
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [6:0] ROW2_BASE = 7'h40;

  // Only 0x00-0x0F (row 1) and 0x40-0x4F (row 2) map to visible cells.
  function automatic logic addr_valid(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == ROW2_BASE[6:4]);
  endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// Brings the asynchronous LCD bus into the clk domain and emits a one-cycle
// transaction strobe, with the bus fields captured, on each falling edge of
// the synchronized enable.
module lcd_en_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       txn_vld_p1,
  output logic       txn_rs_p1,
  output logic       txn_rw_p1,
  output logic [7:0] txn_data_p1
);

  // Fewer than two flops would not resolve metastability, so clamp.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] en_sync_p0;
  logic [9:0]    bus_sync_p0 [NS];
  logic          en_last_p0;
  logic          en_fall_p0;

  // Synchronizer chains; bus fields travel at the same depth as the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sync_p0 <= '0;
      en_last_p0 <= 1'b0;
      for (int i = 0; i < NS; i++) bus_sync_p0[i] <= '0;
    end else begin
      en_sync_p0     <= {en_sync_p0[NS-2:0], lcd_en};
      en_last_p0     <= en_sync_p0[NS-1];
      bus_sync_p0[0] <= {lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < NS; i++) bus_sync_p0[i] <= bus_sync_p0[i-1];
    end
  end

  assign en_fall_p0 = en_last_p0 & ~en_sync_p0[NS-1];

  // ---- p0 -> p1: register the strobe and the bus value seen with it ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_vld_p1  <= 1'b0;
      txn_rs_p1   <= 1'b0;
      txn_rw_p1   <= 1'b0;
      txn_data_p1 <= '0;
    end else begin
      txn_vld_p1 <= en_fall_p0;
      if (en_fall_p0) {txn_rs_p1, txn_rw_p1, txn_data_p1} <= bus_sync_p0[NS-1];
    end
  end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Decodes a write-only HD44780-style parallel bus into a 2x16 character
// buffer plus status flags. Optional macro LCD_DEC_BLANK_EN: when defined,
// the row outputs read as spaces while the display is off (buffer retained).
module lcd_bus_decoder
  import t10_lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_en,
  input  logic         lcd_rw,
  input  logic         lcd_rs,
  input  logic [7:0]   lcd_data,
  output logic [127:0] row_1,
  output logic [127:0] row_2,
  output logic         disp_on,
  output logic         initialized,
  output logic         frame_done,
  output logic         cmd_err
);

  logic       txn_vld_p1;
  logic       txn_rs_p1;
  logic       txn_rw_p1;
  logic [7:0] txn_data_p1;

  lcd_state_e state_q, state_d;

  logic [7:0] cell_q [32];
  logic [6:0] addr_q;
  logic       inc_q;
  logic       disp_on_q;
  logic       err_q;
  logic       frame_done_q;

  logic       do_clear, do_home, do_entry, do_disp, do_addr, do_write, set_err;
  logic [3:0] col_next;
  logic [4:0] cell_idx;
  logic [127:0] buf_1, buf_2;

  lcd_en_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data    (lcd_data),
    .txn_vld_p1  (txn_vld_p1),
    .txn_rs_p1   (txn_rs_p1),
    .txn_rw_p1   (txn_rw_p1),
    .txn_data_p1 (txn_data_p1)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_WAIT_FUNC;
    else      state_q <= state_d;
  end

  // Next state and per-transaction action strobes.
  always_comb begin
    state_d  = state_q;
    do_clear = 1'b0;
    do_home  = 1'b0;
    do_entry = 1'b0;
    do_disp  = 1'b0;
    do_addr  = 1'b0;
    do_write = 1'b0;
    set_err  = 1'b0;
    if (txn_vld_p1) begin
      if (txn_rw_p1) begin
        // Reads are not supported: flag and drop.
        set_err = 1'b1;
      end else if (state_q == ST_WAIT_FUNC) begin
        if (!txn_rs_p1 && txn_data_p1[7:5] == CMD_FUNC[7:5]) state_d = ST_CONFIG;
      end else if (!txn_rs_p1) begin
        if (txn_data_p1 == CMD_CLEAR) begin
          do_clear = 1'b1;
        end else if (txn_data_p1[7:1] == CMD_HOME[7:1]) begin
          do_home = 1'b1;
        end else if (txn_data_p1[7:2] == CMD_ENTRY[7:2]) begin
          do_entry = 1'b1;
        end else if (txn_data_p1[7:3] == CMD_DISP[7:3]) begin
          do_disp = 1'b1;
          if (state_q == ST_CONFIG && txn_data_p1[2])     state_d = ST_RUN;
          else if (state_q == ST_RUN && !txn_data_p1[2])  state_d = ST_CONFIG;
        end else if (txn_data_p1[7] == CMD_DDRAM[7]) begin
          do_addr = 1'b1;
          if (!addr_valid(txn_data_p1[6:0])) set_err = 1'b1;
        end
      end else if (state_q == ST_RUN && addr_valid(addr_q)) begin
        do_write = 1'b1;
      end
    end
  end

  assign col_next = inc_q ? (addr_q[3:0] + 4'd1) : (addr_q[3:0] - 4'd1);
  assign cell_idx = {addr_q[6], addr_q[3:0]};

  // ---- p1 -> p2: apply the decoded transaction to buffer and flags ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) cell_q[i] <= SPACE;
      addr_q       <= '0;
      inc_q        <= 1'b1;
      disp_on_q    <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (set_err)  err_q     <= 1'b1;
      if (do_entry) inc_q     <= txn_data_p1[1];
      if (do_disp)  disp_on_q <= txn_data_p1[2];
      if (do_addr)  addr_q    <= txn_data_p1[6:0];
      if (do_home)  addr_q    <= '0;
      if (do_clear) begin
        for (int i = 0; i < 32; i++) cell_q[i] <= SPACE;
        addr_q <= '0;
      end
      if (do_write) begin
        cell_q[cell_idx] <= txn_data_p1;
        addr_q           <= {addr_q[6:4], col_next};
        frame_done_q     <= (addr_q == (ROW2_BASE | 7'h0F));
      end
    end
  end

  // Pack the cell array into rows, column 0 in the top byte.
  always_comb begin
    buf_1 = '0;
    buf_2 = '0;
    for (int i = 0; i < 16; i++) begin
      buf_1[8*(15-i) +: 8] = cell_q[i];
      buf_2[8*(15-i) +: 8] = cell_q[16+i];
    end
  end

`ifdef LCD_DEC_BLANK_EN
  assign row_1 = disp_on_q ? buf_1 : {16{SPACE}};
  assign row_2 = disp_on_q ? buf_2 : {16{SPACE}};
`else
  assign row_1 = buf_1;
  assign row_2 = buf_2;
`endif

  assign disp_on     = disp_on_q;
  assign initialized = (state_q == ST_RUN);
  assign frame_done  = frame_done_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: each bus transaction pushes its
// expected output snapshot into a scoreboard; a monitor compares it on the
// exact cycle it should become visible (and checks the cycle before is old).
module tb_lcd_bus_decoder;

  localparam int S = 2;
  localparam logic [258:0] RST_SNAP = {{32{8'h20}}, 3'b000};
  localparam logic [127:0] SPC_ROW  = {16{8'h20}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         lcd_en = 1'b0;
  logic         lcd_rw = 1'b0;
  logic         lcd_rs = 1'b0;
  logic [7:0]   lcd_data = 8'h00;
  logic [127:0] row_1, row_2;
  logic         disp_on, initialized, frame_done, cmd_err;

  lcd_bus_decoder #(.SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_en      (lcd_en),
    .lcd_rw      (lcd_rw),
    .lcd_rs      (lcd_rs),
    .lcd_data    (lcd_data),
    .row_1       (row_1),
    .row_2       (row_2),
    .disp_on     (disp_on),
    .initialized (initialized),
    .frame_done  (frame_done),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;

  typedef struct {
    logic [258:0] exp;
    logic [258:0] prev;
    logic         fd;
    int           due;
  } item_t;
  item_t sb[$];

  // Reference model state
  logic [7:0] m_cell [32];
  logic [6:0] m_addr;
  logic       m_inc, m_disp, m_err;
  int         m_state;

  function automatic logic [258:0] dut_snap();
    return {row_1, row_2, disp_on, initialized, cmd_err};
  endfunction

  function automatic logic [127:0] m_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[8*(15-i) +: 8] = m_cell[16*r+i];
`ifdef LCD_DEC_BLANK_EN
    if (!m_disp) v = SPC_ROW;
`endif
    return v;
  endfunction

  function automatic logic [258:0] m_snap();
    return {m_row(0), m_row(1), m_disp, (m_state == 2), m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
    m_addr = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_err = 1'b0; m_state = 0;
  endtask

  task automatic model_txn(input logic rs, input logic rw, input logic [7:0] d,
                           output logic fd);
    logic ok;
    logic [3:0] col;
    fd = 1'b0;
    ok = (m_addr <= 7'h0F) || (m_addr >= 7'h40 && m_addr <= 7'h4F);
    if (rw) m_err = 1'b1;
    else if (m_state == 0) begin
      if (!rs && d[7:5] == 3'b001) m_state = 1;
    end else if (!rs) begin
      if (d == 8'h01) begin
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_addr = 7'h00;
      end else if (d == 8'h02 || d == 8'h03) m_addr = 7'h00;
      else if (d >= 8'h04 && d <= 8'h07) m_inc = d[1];
      else if (d >= 8'h08 && d <= 8'h0F) begin
        m_disp = d[2];
        if (m_state == 1 && d[2]) m_state = 2;
        else if (m_state == 2 && !d[2]) m_state = 1;
      end else if (d >= 8'h80) begin
        m_addr = d[6:0];
        if (!((m_addr <= 7'h0F) || (m_addr >= 7'h40 && m_addr <= 7'h4F))) m_err = 1'b1;
      end
    end else if (m_state == 2 && ok) begin
      m_cell[(m_addr >= 7'h40 ? 16 : 0) + int'(m_addr[3:0])] = d;
      fd  = (m_addr == 7'h4F);
      col = m_inc ? m_addr[3:0] + 4'd1 : m_addr[3:0] - 4'd1;
      m_addr = {m_addr[6:4], col};
    end
  endtask

  task automatic chk(input string nm, input logic [258:0] act, input logic [258:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus write: enable high for three cycles, then falls with data held.
  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    item_t it;
    logic  fd;
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    it.prev = m_snap();
    model_txn(rs, rw, d, fd);
    it.exp = m_snap();
    it.fd  = fd;
    it.due = cyc + S + 2;
    lcd_en = 1'b0;
    sb.push_back(it);
    repeat (S + 4) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);  send(1'b0, 1'b0, d); endtask
  task automatic chr(input logic [7:0] d);  send(1'b1, 1'b0, d); endtask

  // Monitor: compares each scoreboard entry on its visibility cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (cyc == sb[0].due - 1) begin
        chk("latency_early", dut_snap(), sb[0].prev);
      end else if (cyc == sb[0].due) begin
        chk("sb_outputs", dut_snap(), sb[0].exp);
        chk("sb_frame_done", {258'd0, frame_done}, {258'd0, sb[0].fd});
        void'(sb.pop_front());
      end else if (cyc > sb[0].due) begin
        tests++; fails++;
        $display("FAIL sb_overdue: cycle %0d past due %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  logic [127:0] saved;
  logic [7:0]   b;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", dut_snap(), RST_SNAP);
    chk("reset_frame_done", {258'd0, frame_done}, 259'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Character before any function set is ignored
    chr(8'h41);
    chk("pre_init_row1", {131'd0, row_1}, {131'd0, SPC_ROW});
    chk("pre_init_row2", {131'd0, row_2}, {131'd0, SPC_ROW});
    chk("pre_init_init", {258'd0, initialized}, 259'd0);

    // Standard init then "HI"
    cmd(8'h38); cmd(8'h08); cmd(8'h01); cmd(8'h06); cmd(8'h0C); cmd(8'h80);
    chr(8'h48); chr(8'h49);
    chk("init_row1", {131'd0, row_1}, {131'd0, 16'h4849, {14{8'h20}}});
    chk("init_disp_on", {258'd0, disp_on}, {258'd0, 1'b1});
    chk("init_initialized", {258'd0, initialized}, {258'd0, 1'b1});

    // Fill row 2, expect one frame_done, then wrap to column 0
    chk("fd_before", 259'(fd_cnt), 259'd0);
    cmd(8'hC0);
    for (int i = 0; i < 16; i++) begin
      b = 8'h41 + 8'(i);
      chr(b);
    end
    chk("row2_alpha", {131'd0, row_2}, {131'd0, 128'("ABCDEFGHIJKLMNOP")});
    chk("fd_after", 259'(fd_cnt), 259'd1);
    chr(8'h51);
    chk("row2_wrap", {251'd0, row_2[127:120]}, {251'd0, 8'h51});

    // Invalid address blocks writes; a valid one re-enables them
    cmd(8'h90);
    chk("bad_addr_err", {258'd0, cmd_err}, {258'd0, 1'b1});
    saved = row_1;
    chr(8'h5A);
    chk("bad_addr_blocked", {131'd0, row_1}, {131'd0, saved});
    cmd(8'h85); chr(8'h5A);
    chk("readdr_write", {251'd0, row_1[87:80]}, {251'd0, 8'h5A});
    chk("err_sticky", {258'd0, cmd_err}, {258'd0, 1'b1});

    // Decrement mode wraps column 0 -> 15
    cmd(8'h04); cmd(8'h80); chr(8'h58); chr(8'h59);
    chk("dec_col0", {251'd0, row_1[127:120]}, {251'd0, 8'h58});
    chk("dec_col15", {251'd0, row_1[7:0]}, {251'd0, 8'h59});

    // Clear, then display off/on
    cmd(8'h01);
    chk("clear_row1", {131'd0, row_1}, {131'd0, SPC_ROW});
    chk("clear_row2", {131'd0, row_2}, {131'd0, SPC_ROW});
    cmd(8'h06); chr(8'h48); chr(8'h49);
    cmd(8'h08);
    chk("disp_off_flag", {257'd0, disp_on, initialized}, 259'd0);
`ifdef LCD_DEC_BLANK_EN
    chk("disp_off_row1", {131'd0, row_1}, {131'd0, SPC_ROW});
`else
    chk("disp_off_row1", {131'd0, row_1}, {131'd0, 16'h4849, {14{8'h20}}});
`endif
    cmd(8'h0C);
    chk("disp_on_row1", {131'd0, row_1}, {131'd0, 16'h4849, {14{8'h20}}});

    // Reset while enable is high: immediate reset values, transaction dropped
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h55; lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset", dut_snap(), RST_SNAP);
    model_reset();
    @(negedge clk);
    lcd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (S + 6) @(negedge clk);
    chk("reset_discard", dut_snap(), RST_SNAP);

    // Read request flags an error and changes nothing else
    send(1'b1, 1'b1, 8'h41);
    chk("read_err", {258'd0, cmd_err}, {258'd0, 1'b1});
    chk("read_rows", {3'd0, row_1, row_2}, {3'd0, SPC_ROW, SPC_ROW});

    for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL sb_drain: %0d entries left", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
